// File: rtl/btb_table.sv
// Branch target buffer: 8 fully associative entries fed by an in-order
// update queue, with a sequential whole-table flush sweep.
module btb_table #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [52:0] predictor [7:0],
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [20:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush,
  output logic        busy
);

  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [20:0] INV_TAG = 21'h1FFFFF;

  typedef enum logic {
    IDLE,
    FLUSH
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [53:0]   r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;

  logic [52:0] r_tab [7:0];
  logic [2:0]  r_rr;
  logic [2:0]  r_sweep;

  logic        w_push;
  logic        w_pop;
  logic        w_commit;
  logic [53:0] w_head;
  logic        w_h_taken;
  logic [20:0] w_h_pc;
  logic [31:0] w_h_tgt;
  logic        w_hit;
  logic [2:0]  w_hit_idx;
  logic        w_free;
  logic [2:0]  w_free_idx;

  assign upd_ready = (r_count < DEPTH_C);
  assign busy      = (r_state == FLUSH);
  assign predictor = r_tab;

  assign w_push = upd_valid && upd_ready;
  assign w_pop  = (r_state == IDLE) && !flush
               && (r_count != '0);

  assign w_head    = r_fifo[r_rptr];
  assign w_h_taken = w_head[53];
  assign w_h_pc    = w_head[52:32];
  assign w_h_tgt   = w_head[31:0];
  assign w_commit  = w_pop && (w_h_pc != INV_TAG);

  // Descending scan so the lowest matching index wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = 3'd0;
    w_free     = 1'b0;
    w_free_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_tab[i][52:32] == w_h_pc) begin
        w_hit     = 1'b1;
        w_hit_idx = 3'(i);
      end
      if (r_tab[i][52:32] == INV_TAG) begin
        w_free     = 1'b1;
        w_free_idx = 3'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      flush:
        w_state_nxt = FLUSH;
      (!flush && r_state == FLUSH
        && r_sweep == 3'd7):
        w_state_nxt = IDLE;
      default:
        w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= {upd_taken, upd_pc, upd_target};
        r_wptr         <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        r_tab[i] <= {INV_TAG, 32'd0};
      end
      r_rr    <= 3'd0;
      r_sweep <= 3'd0;
    end else if (flush) begin
      r_rr    <= 3'd0;
      r_sweep <= 3'd0;
    end else if (r_state == FLUSH) begin
      r_tab[r_sweep] <= {INV_TAG, 32'd0};
      r_sweep        <= r_sweep + 3'd1;
    end else if (w_commit) begin
      if (w_h_taken) begin
        if (w_hit) begin
          r_tab[w_hit_idx][31:0] <= w_h_tgt;
        end else if (w_free) begin
          r_tab[w_free_idx] <= {w_h_pc, w_h_tgt};
        end else begin
          r_tab[r_rr] <= {w_h_pc, w_h_tgt};
          r_rr        <= r_rr + 3'd1;
        end
      end else if (w_hit) begin
        r_tab[w_hit_idx] <= {INV_TAG, 32'd0};
      end
    end
  end

endmodule

// File: doc/btb_table.md
BTB_TABLE -- requirements
Module: btb_table

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, depth of the update queue (legal values 2 or 4).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port predictor  output  [52:0] x8 (unpacked [7:0])  BTB entry array for the lookup stage; [52:32] tag (PC bits), [31:0] target.
REQ-005 SHALL have port upd_valid  input  1  branch-resolution update request.
REQ-006 SHALL have port upd_ready  output  1  queue can accept (count < FIFO_DEPTH).
REQ-007 SHALL have port upd_pc  input  21  resolved branch PC tag.
REQ-008 SHALL have port upd_target  input  32  resolved branch target, stored verbatim.
REQ-009 SHALL have port upd_taken  input  1  branch resolved taken.
REQ-010 SHALL have port flush  input  1  single-cycle request to invalidate the whole table.
REQ-011 SHALL have port busy  output  1  high while in state FLUSH.

Function
REQ-012 Tag 21'h1FFFFF SHALL be the reserved invalid tag; an entry is valid iff its tag differs from it.
REQ-013 An update with upd_pc == 21'h1FFFFF SHALL be accepted and discarded without a table write.
REQ-014 An update SHALL be accepted on an edge where upd_valid && upd_ready; it is pushed into an in-order FIFO.
REQ-015 States SHALL be IDLE and FLUSH; in IDLE, when the FIFO is non-empty, exactly one entry SHALL be popped and committed per edge.
REQ-016 Latency: an update accepted at edge E into an empty FIFO SHALL be visible on predictor after edge E+1.
REQ-017 Simultaneous push and pop SHALL be allowed; count stays unchanged; push into a full FIFO is impossible because upd_ready is low.
REQ-018 Commit SHALL search all 8 entries for tag == upd_pc (lowest index on multiple matches).
REQ-019 Taken and match: target of the matching entry SHALL be overwritten.
REQ-020 Taken and no match: the lowest-index invalid entry SHALL be written with {upd_pc, upd_target}; if none is invalid, the entry at the 3-bit round-robin pointer is written and the pointer increments mod 8.
REQ-021 Round-robin pointer SHALL advance only on victim replacement, wrapping 7 -> 0.
REQ-022 Not taken and match: the matching entry SHALL be invalidated (tag 21'h1FFFFF, target 0).
REQ-023 Not taken and no match: no table change.
REQ-024 flush sampled high SHALL enter FLUSH, discard FIFO contents including any same-edge push, reset pointer to 0, and suppress any same-edge commit.
REQ-025 FLUSH SHALL invalidate entry k on the k-th edge after entry (k = 0..7), then return to IDLE on the edge invalidating entry 7; busy high throughout (8 cycles).
REQ-026 No commit SHALL occur in FLUSH; pushes are still accepted and held.
REQ-027 flush sampled high while in FLUSH SHALL restart the sweep at entry 0 and re-discard the FIFO.
REQ-028 upd_ready SHALL be combinational from count only, independent of state.

Reset
REQ-029 While rst_n is low: all tags 21'h1FFFFF, all targets 0, pointer 0, FIFO empty, state IDLE, busy 0, upd_ready 1.
REQ-030 Reset asserted mid-FLUSH or with a non-empty FIFO SHALL abandon the operation immediately; no partial write survives.

Verification
REQ-031 After reset, push {pc=21'h00010, tgt=32'h80000040, taken=1} -> predictor[0] == {21'h00010, 32'h80000040} one edge after acceptance; others invalid.
REQ-032 Fill 8 distinct PCs taken, then push a 9th (pc=21'h00100) -> written to entry 0, pointer 1; a 10th -> entry 1, pointer 2.
REQ-033 Entry 3 holds pc 21'h00030, push same pc taken=0 -> entry 3 tag 21'h1FFFFF, target 0; push again taken=0 -> no change.
REQ-034 Hold upd_valid high with FLUSH active and FIFO_DEPTH=2 -> upd_ready drops after 2 accepts; on return to IDLE commits drain one per edge.
REQ-035 Assert flush in the same cycle as an accepted push -> push discarded, busy high 8 cycles, all tags 21'h1FFFFF at end; re-assert flush at sweep cycle 4 -> busy lasts 8 further cycles.
REQ-036 Push pc=21'h1FFFFF taken=1 -> accepted, table unchanged; drop rst_n during FLUSH -> immediate reset values of REQ-029.
